hazard_scoreboard_ctrl: RTL and testbench

Pipeline hazard controller for the IF/ID/EX front end. It keeps a per-register scoreboard of in-flight destination writes and generates the decoder's `valid`, `kill` and `stall` controls. This replaces per-format combinational RAW comparison against the EX/MEM stage registers. It also sequences the multi-cycle flush after a taken branch or jump is resolved in EX.

---
 rtl/hazard_scoreboard_ctrl_pkg.sv | 17 +
 rtl/hazard_scoreboard_ctrl_if.sv | 42 ++++
 rtl/hazard_scoreboard_ctrl_reg_scoreboard.sv | 50 +++++
 rtl/hazard_scoreboard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared types and default parameters for the pipeline hazard controller.
package HazardPkg;

    // Architectural register index (x0..x31).
    typedef logic [4:0] reg_idx_t;

    // Flush sequencer states: normal operation, or killing wrong-path fetches.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_t;

    localparam int NUM_REGS_DEF    = 32;
    localparam int WB_LATENCY_DEF  = 3;
    localparam int KILL_CYCLES_DEF = 2;

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// Bundle between the ID stage / EX redirect source and the hazard controller.
//
// Handshake: the ID stage presents an instruction by raising id_valid.
// The instruction advances to EX in the cycle that issue is high.
// While stall is high, the ID stage must hold every id_* field steady
// and keep id_valid high. While kill is high, the ID instruction is
// discarded and never issues. Nothing is ever both issued and stalled.
interface hazard_scoreboard_ctrl_if
    import HazardPkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF
);
    logic                id_valid;
    reg_idx_t            id_rs1;
    reg_idx_t            id_rs2;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    reg_idx_t            id_rd;
    logic                id_regwrite;
    logic                redirect;

    logic                valid;
    logic                kill;
    logic                stall;
    logic                issue;
    logic [NUM_REGS-1:0] busy_vec;
    fsm_t                flush_state;

    // Pipeline side: drives the ID instruction and redirect, observes controls.
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_regwrite, redirect,
        input  valid, kill, stall, issue, busy_vec, flush_state
    );

    // Controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_regwrite, redirect,
        output valid, kill, stall, issue, busy_vec, flush_state
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl_reg_scoreboard.sv
// Per-register countdown of in-flight writes. An entry is busy while its
// count is nonzero; issuing a writer reloads it with the write-back latency.
module reg_scoreboard
    import HazardPkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int WB_LATENCY = WB_LATENCY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  reg_idx_t            set_idx,
    input  reg_idx_t            rs1,
    input  reg_idx_t            rs2,
    output logic                busy_rs1,
    output logic                busy_rs2,
    output logic [NUM_REGS-1:0] busy_vec
);
    localparam int CW = $clog2(WB_LATENCY + 1);

    logic [NUM_REGS-1:0][CW-1:0] cnt;

    // Count down every live entry; a new write to the same entry wins. x0 is never tracked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (set_en && (set_idx == reg_idx_t'(i))) begin
                    cnt[i] <= CW'(WB_LATENCY);
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    // Busy flags and the two source lookups use the pre-update counts.
    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

    assign busy_rs1 = busy_vec[rs1];
    assign busy_rs2 = busy_vec[rs2];

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// IF/ID/EX hazard controller: scoreboard-based RAW stall plus the
// multi-cycle kill sequence after an EX redirect.
module hazard_scoreboard_ctrl
    import HazardPkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int WB_LATENCY  = WB_LATENCY_DEF,
    parameter int KILL_CYCLES = KILL_CYCLES_DEF
) (
    input logic                     clk,
    input logic                     rst,
    hazard_scoreboard_ctrl_if.slave bus
);
    localparam int KW = $clog2(KILL_CYCLES + 1);

    fsm_t                state;
    fsm_t                state_nxt;
    logic [KW-1:0]       kill_cnt;
    logic [KW-1:0]       kill_cnt_nxt;

    logic                busy_rs1;
    logic                busy_rs2;
    logic [NUM_REGS-1:0] sb_busy_vec;
    logic                hazard;
    logic                kill_int;
    logic                stall_int;
    logic                issue_int;
    logic                sb_set;

    reg_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .WB_LATENCY (WB_LATENCY)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_idx  (bus.id_rd),
        .rs1      (bus.id_rs1),
        .rs2      (bus.id_rs2),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_vec (sb_busy_vec)
    );

    // Flush sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            kill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            kill_cnt <= kill_cnt_nxt;
        end
    end

    // Flush sequencer next state: the redirect cycle kills on its own, FLUSH covers the rest.
    always_comb begin
        state_nxt    = state;
        kill_cnt_nxt = kill_cnt;
        case (state)
            RUN: begin
                if (bus.redirect && (KILL_CYCLES > 1)) begin
                    state_nxt    = FLUSH;
                    kill_cnt_nxt = KW'(KILL_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (bus.redirect) begin
                    kill_cnt_nxt = KW'(KILL_CYCLES - 1);
                end else if (kill_cnt == KW'(1)) begin
                    state_nxt    = RUN;
                    kill_cnt_nxt = '0;
                end else begin
                    kill_cnt_nxt = kill_cnt - KW'(1);
                end
            end
            default: begin
                state_nxt    = RUN;
                kill_cnt_nxt = '0;
            end
        endcase
    end

    // Decoder controls; reset forces every output low without waiting for a clock.
    always_comb begin
        hazard    = bus.id_valid && ((bus.id_uses_rs1 && busy_rs1) ||
                                     (bus.id_uses_rs2 && busy_rs2));
        kill_int  = !rst && (bus.redirect || (state == FLUSH));
        stall_int = !rst && hazard && !kill_int;
        issue_int = !rst && bus.id_valid && !stall_int && !kill_int;
        sb_set    = issue_int && bus.id_regwrite && (bus.id_rd != '0);
    end

    assign bus.kill        = kill_int;
    assign bus.stall       = stall_int;
    assign bus.issue       = issue_int;
    assign bus.valid       = !rst && bus.id_valid && !kill_int;
    assign bus.busy_vec    = sb_busy_vec;
    assign bus.flush_state = state;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: cycle-by-cycle vector table with an
// expected-output queue, plus hand sequences for reset corner cases.
module tb_hazard_scoreboard_ctrl;
    import HazardPkg::*;

    localparam int NR = 32;
    localparam int W  = 4 + NR;   // {valid, kill, stall, issue, busy_vec}

    typedef struct {
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       redir;
        logic [3:0] exp_ctl;   // {valid, kill, stall, issue}
        logic [NR-1:0] exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t          vq[$];
    logic [W-1:0]  exp_q[$];

    hazard_scoreboard_ctrl_if #(.NUM_REGS(NR)) bus ();

    hazard_scoreboard_ctrl #(
        .NUM_REGS    (NR),
        .WB_LATENCY  (3),
        .KILL_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [NR-1:0] b(input int n);
        logic [NR-1:0] one;
        one = '0;
        one[n] = 1'b1;
        return one;
    endfunction

    task automatic add(input logic idv, input int rs1, input int rs2,
                       input logic u1, input logic u2, input int rd,
                       input logic rw, input logic redir,
                       input logic [3:0] ctl, input logic [NR-1:0] busy);
        vec_t v;
        v.idv = idv; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
        v.rd = 5'(rd); v.rw = rw; v.redir = redir;
        v.exp_ctl = ctl; v.exp_busy = busy;
        vq.push_back(v);
    endtask

    task automatic drive_idle();
        bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.id_rd = '0; bus.id_regwrite = 1'b0; bus.redirect = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.id_valid    = v.idv;
        // Unused source fields get random values; they must not matter.
        bus.id_rs1      = v.u1 ? v.rs1 : 5'($urandom_range(0, 31));
        bus.id_rs2      = v.u2 ? v.rs2 : 5'($urandom_range(0, 31));
        bus.id_uses_rs1 = v.u1;
        bus.id_uses_rs2 = v.u2;
        bus.id_rd       = v.rd;
        bus.id_regwrite = v.rw;
        bus.redirect    = v.redir;
    endtask

    function automatic logic [W-1:0] outs();
        return {bus.valid, bus.kill, bus.stall, bus.issue, bus.busy_vec};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input fsm_t exp);
        check(name, W'(bus.flush_state), W'(exp));
    endtask

    // Watchdog
    initial begin
        #200000;
        n_miss++;
        $display("FAIL watchdog: run did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        logic [W-1:0] exp;

        // ---- table: {idv, rs1, rs2, u1, u2, rd, rw, redir, {v,k,s,i}, busy} ----
        // RAW stall on x5 (three stall cycles)
        add(1, 0, 0, 0, 0,  5, 1, 0, 4'b1001, '0);
        add(1, 5, 0, 1, 0,  8, 1, 0, 4'b1010, b(5));
        add(1, 5, 0, 1, 0,  8, 1, 0, 4'b1010, b(5));
        add(1, 5, 0, 1, 0,  8, 1, 0, 4'b1010, b(5));
        add(1, 5, 0, 1, 0,  8, 1, 0, 4'b1001, '0);
        // rs1 == rs2 == busy x8: single stall of the same length
        add(1, 8, 8, 1, 1,  9, 1, 0, 4'b1010, b(8));
        add(1, 8, 8, 1, 1,  9, 1, 0, 4'b1010, b(8));
        add(1, 8, 8, 1, 1,  9, 1, 0, 4'b1010, b(8));
        add(1, 8, 8, 1, 1,  9, 1, 0, 4'b1001, '0);
        // rd == rs1 on the issuing instruction: no self-hazard
        add(1, 10, 0, 1, 0, 10, 1, 0, 4'b1001, b(9));
        // id_valid = 0: scoreboard keeps counting down
        add(0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, b(9) | b(10));
        add(0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, b(9) | b(10));
        add(0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, b(10));
        add(0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, '0);
        // x0 and no-regwrite never mark busy
        add(1, 0, 0, 0, 0,  0, 1, 0, 4'b1001, '0);
        add(1, 0, 0, 1, 0,  6, 0, 0, 4'b1001, '0);
        add(1, 0, 6, 0, 1,  0, 0, 0, 4'b1001, '0);
        // single redirect: two kill cycles, killed rd=7 never tracked
        add(1, 0, 0, 0, 0,  7, 1, 1, 4'b0100, '0);
        add(1, 0, 0, 0, 0,  7, 1, 0, 4'b0100, '0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, '0);
        // back-to-back redirect extends the kill window
        add(1, 0, 0, 0, 0,  7, 1, 1, 4'b0100, '0);
        add(1, 0, 0, 0, 0,  7, 1, 1, 4'b0100, '0);
        add(1, 0, 0, 0, 0,  7, 1, 0, 4'b0100, '0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, '0);
        // kill over stall; busy entry keeps draining under kill
        add(1, 0, 0, 0, 0, 11, 1, 0, 4'b1001, '0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, b(11));
        add(1, 11, 0, 1, 0, 0, 0, 1, 4'b0100, b(11));
        add(1, 11, 0, 1, 0, 0, 0, 0, 4'b0100, b(11));
        add(1, 11, 0, 1, 0, 0, 0, 0, 4'b1001, '0);

        // ---- reset behaviour ----
        drive_idle();
        bus.id_valid = 1'b1;
        @(negedge clk);
        check("reset_hold", outs(), '0);
        bus.redirect = 1'b1;
        #1;
        check("reset_hold_redirect", outs(), '0);
        bus.redirect = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_release", outs(), {4'b1001, {NR{1'b0}}});
        check_state("reset_release_state", RUN);

        // ---- table-driven vectors through the expected queue ----
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            drive_vec(vq[i]);
            exp_q.push_back({vq[i].exp_ctl, vq[i].exp_busy});
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL vec%0d expected queue empty", i);
            end else begin
                exp = exp_q.pop_front();
                check($sformatf("vec%0d", i), outs(), exp);
            end
        end

        // ---- asynchronous reset mid-stall ----
        @(posedge clk);
        #1;
        drive_idle();
        bus.id_valid = 1'b1; bus.id_rd = 5'd12; bus.id_regwrite = 1'b1;
        @(posedge clk);
        #1;
        bus.id_rd = 5'd0; bus.id_regwrite = 1'b0;
        bus.id_uses_rs1 = 1'b1; bus.id_rs1 = 5'd12;
        @(negedge clk);
        check("midstall_pre", outs(), {4'b1010, b(12)});
        #1 rst = 1'b1;
        #1;
        check("midstall_async", outs(), '0);
        check_state("midstall_state", RUN);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midstall_after", outs(), {4'b1001, {NR{1'b0}}});

        // ---- asynchronous reset mid-flush ----
        @(posedge clk);
        #1;
        drive_idle();
        bus.id_valid = 1'b1; bus.redirect = 1'b1;
        @(posedge clk);
        #1 bus.redirect = 1'b0;
        @(negedge clk);
        check("midflush_pre", outs(), {4'b0100, {NR{1'b0}}});
        check_state("midflush_pre_state", FLUSH);
        #1 rst = 1'b1;
        #1;
        check("midflush_async", outs(), '0);
        check_state("midflush_state", RUN);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midflush_after", outs(), {4'b1001, {NR{1'b0}}});
        check_state("midflush_after_state", RUN);

        // every queued expectation must have been consumed
        check("exp_q_drained", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
